rtc_seg_clock: RTL and testbench

Parametrised real-time clock with an 8-digit multiplexed seven-segment driver for the EGo1 board's two 4-digit display groups. It keeps hours, minutes and seconds from a divided system clock and supports run/pause, synchronous time loading and a 12/24-hour display mode. It displays HH-MM-SS, with the digit-enable and segment outputs registered in the same cycle. It sits at top level between the 100 MHz board clock and the display pins.

---
 rtl/rtc_seg_clock.sv | 175 +++++++++++++++++
 tb/tb_rtc_seg_clock.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_seg_clock.sv
// Real-time clock (HH-MM-SS) with run/pause, checked time load, 12/24-hour view
// and an 8-digit multiplexed seven-segment driver with registered digit/segment outputs.
module rtc_seg_clock #(
    parameter int CLK_HZ   = 100000000,
    parameter int SCAN_DIV = 200000,
    parameter int INIT_H   = 0,
    parameter int INIT_M   = 0,
    parameter int INIT_S   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode12,
    input  logic       set_en,
    input  logic [4:0] set_h,
    input  logic [5:0] set_m,
    input  logic [5:0] set_s,
    output logic       set_ack,
    output logic       set_err,
    output logic       sec_tick,
    output logic [7:0] seg_data1,
    output logic [7:0] seg_data2,
    output logic [7:0] seg_which
);

    localparam int TW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          sec_tick_q, sec_tick_d;
    logic          set_ack_q, set_ack_d;
    logic          set_err_q, set_err_d;
    logic [7:0]    seg_which_q, seg_which_d;
    logic [7:0]    seg_data_q, seg_data_d;

    logic          load_ok;
    logic          tick;
    logic          scan_wrap;
    logic [5:0]    disp_h;
    logic [3:0]    digit;

    // Values never exceed 59, so a compare ladder replaces a divider.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd50)      return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] u;
        t = {2'b00, tens_of(v)};
        u = v - t * 6'd10;
        return u[3:0];
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE0;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            4'd10:   return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        load_ok = set_en && (set_h <= 5'd23) && (set_m <= 6'd59) && (set_s <= 6'd59);
        tick    = run && (tick_cnt_q == TICK_LAST);
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_cnt_d = (!run || load_ok || tick) ? '0 : tick_cnt_q + TW'(1);
        if (load_ok) begin
            hour_d = set_h;
            min_d  = set_m;
            sec_d  = set_s;
        end else if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        sec_tick_d = tick && !load_ok;
        set_ack_d  = load_ok;
        set_err_d  = set_en && !load_ok;
    end

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SW'(1);
        idx_d      = scan_wrap ? idx_q + 3'd1 : idx_q;

        disp_h = {1'b0, hour_q};
        if (mode12) begin
            if (hour_q == 5'd0)       disp_h = 6'd12;
            else if (hour_q > 5'd12)  disp_h = {1'b0, hour_q} - 6'd12;
        end

        case (idx_q)
            3'd0:    digit = tens_of(disp_h);
            3'd1:    digit = units_of(disp_h);
            3'd3:    digit = tens_of(min_q);
            3'd4:    digit = units_of(min_q);
            3'd6:    digit = tens_of(sec_q);
            3'd7:    digit = units_of(sec_q);
            default: digit = 4'd10;
        endcase

        // PM marker rides on the dp of the hour-units digit, 12-hour view only.
        seg_data_d  = seg_code(digit) |
                      {7'b0, mode12 && (hour_q >= 5'd12) && (idx_q == 3'd1)};
        seg_which_d = 8'h80 >> idx_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q  <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= 3'd0;
            hour_q      <= 5'(INIT_H);
            min_q       <= 6'(INIT_M);
            sec_q       <= 6'(INIT_S);
            sec_tick_q  <= 1'b0;
            set_ack_q   <= 1'b0;
            set_err_q   <= 1'b0;
            seg_which_q <= 8'h00;
            seg_data_q  <= 8'h00;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_tick_q  <= sec_tick_d;
            set_ack_q   <= set_ack_d;
            set_err_q   <= set_err_d;
            seg_which_q <= seg_which_d;
            seg_data_q  <= seg_data_d;
        end
    end

    assign sec_tick  = sec_tick_q;
    assign set_ack   = set_ack_q;
    assign set_err   = set_err_q;
    assign seg_which = seg_which_q;
    assign seg_data1 = seg_data_q;
    assign seg_data2 = seg_data_q;

endmodule

// File: tb/tb_rtc_seg_clock.sv
// Bench for rtc_seg_clock: a seconds-since-midnight reference model checks every cycle,
// plus a load/display vector table and hand sequences for rollover, collision, pause and reset.
module tb_rtc_seg_clock;

    localparam int CLK_HZ   = 4;
    localparam int SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       mode12 = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_h = '0;
    logic [5:0] set_m = '0;
    logic [5:0] set_s = '0;
    logic       set_ack, set_err, sec_tick;
    logic [7:0] seg_data1, seg_data2, seg_which;

    rtc_seg_clock #(
        .CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .INIT_H(0), .INIT_M(0), .INIT_S(0)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .mode12(mode12), .set_en(set_en),
        .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .set_ack(set_ack), .set_err(set_err), .sec_tick(sec_tick),
        .seg_data1(seg_data1), .seg_data2(seg_data2), .seg_which(seg_which)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference state: time as seconds since midnight, cycles into the current
    // second, and cycles since reset release (which fixes the scan slot).
    int m_secs = 0;
    int m_cnt = 0;
    int m_scan = 0;

    logic [7:0] seg_tab [11] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                                 8'hBE, 8'hE0, 8'hFE, 8'hF6, 8'h02};
    logic [7:0] got [8];
    logic [7:0] exp8 [8];

    typedef struct {
        int         h, m, s;
        bit         m12;
        bit         ack, err;
        logic [7:0] d0, d1;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] exp_seg(input int idx, input int secs, input bit m12);
        int h, m, s, hd, dig;
        logic [7:0] code;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        hd = m12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        case (idx)
            0: dig = hd / 10;
            1: dig = hd % 10;
            3: dig = m / 10;
            4: dig = m % 10;
            6: dig = s / 10;
            7: dig = s % 10;
            default: dig = 10;
        endcase
        code = seg_tab[dig];
        if (m12 && h >= 12 && idx == 1) code[0] = 1'b1;
        return code;
    endfunction

    task automatic step();
        logic [7:0] e_which, e_data;
        logic [2:0] e_pulse;
        int idx;
        bit lok, tk;
        if (!rst) begin
            e_which = 8'h00; e_data = 8'h00; e_pulse = 3'b000;
            m_secs = 0; m_cnt = 0; m_scan = 0;
        end else begin
            idx     = (m_scan / SCAN_DIV) % 8;
            e_which = 8'h80 >> idx;
            e_data  = exp_seg(idx, m_secs, mode12);
            lok = set_en && set_h <= 23 && set_m <= 59 && set_s <= 59;
            tk  = run && (m_cnt == CLK_HZ - 1);
            e_pulse = {tk && !lok, lok, set_en && !lok};
            if (lok) m_secs = int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s);
            else if (tk) m_secs = (m_secs + 1) % 86400;
            m_cnt = (!run || lok || tk) ? 0 : m_cnt + 1;
            m_scan++;
        end
        @(posedge clk);
        #1;
        chk("seg_which", seg_which, e_which);
        chk("seg_data1", seg_data1, e_data);
        chk("seg_data2", seg_data2, e_data);
        chk("tick_ack_err", {sec_tick, set_ack, set_err}, e_pulse);
    endtask

    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (sec_tick) begin
                n = i;
                break;
            end
        end
        if (n < 0) chk("tick_timeout", 0, 1);
    endtask

    task automatic scan_digits();
        for (int i = 0; i < 8; i++) got[i] = 8'hEE;
        for (int k = 0; k < 16; k++) begin
            step();
            for (int i = 0; i < 8; i++)
                if (seg_which == (8'h80 >> i)) got[i] = seg_data1;
        end
    endtask

    task automatic check_digits(input string nm);
        for (int i = 0; i < 8; i++) chk(nm, got[i], exp8[i]);
    endtask

    task automatic check_zero(input string nm);
        chk(nm, {seg_which, seg_data1, seg_data2, sec_tick, set_ack, set_err}, 27'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] prev;
        int runlen;

        tbl[0] = '{0, 5, 0, 1'b1, 1'b1, 1'b0, 8'h60, 8'hDA};
        tbl[1] = '{13, 0, 0, 1'b1, 1'b1, 1'b0, 8'hFC, 8'h61};
        tbl[2] = '{13, 0, 0, 1'b0, 1'b1, 1'b0, 8'h60, 8'hF2};
        tbl[3] = '{24, 0, 0, 1'b0, 1'b0, 1'b1, 8'h60, 8'hF2};
        tbl[4] = '{12, 34, 56, 1'b0, 1'b1, 1'b0, 8'h60, 8'hDA};
        tbl[5] = '{12, 60, 0, 1'b1, 1'b0, 1'b1, 8'h60, 8'hDB};
        tbl[6] = '{23, 59, 59, 1'b1, 1'b1, 1'b0, 8'h60, 8'h61};
        tbl[7] = '{0, 0, 60, 1'b0, 1'b0, 1'b1, 8'hDA, 8'hF2};
        tbl[8] = '{9, 0, 0, 1'b0, 1'b1, 1'b0, 8'hFC, 8'hF6};
        tbl[9] = '{0, 0, 0, 1'b0, 1'b1, 1'b0, 8'hFC, 8'hFC};

        // Reset state
        #2 rst = 1'b0;
        #1 check_zero("reset_outputs");
        step();
        step();
        rst = 1'b1;

        // First slot and scan alignment over 16 slots
        step();
        chk("first_slot_which", seg_which, 8'h80);
        chk("first_slot_data", seg_data1, 8'hFC);
        prev = seg_which;
        runlen = 1;
        for (int k = 1; k < 32; k++) begin
            step();
            if ((seg_which == 8'h20) || (seg_which == 8'h04)) chk("dash_slot", seg_data1, 8'h02);
            if (seg_which == prev) runlen++;
            else begin
                chk("slot_len", runlen, SCAN_DIV);
                runlen = 1;
                prev = seg_which;
            end
        end

        // Load / display vector table (time frozen)
        for (int v = 0; v < 10; v++) begin
            mode12 = tbl[v].m12;
            set_h = 5'(tbl[v].h);
            set_m = 6'(tbl[v].m);
            set_s = 6'(tbl[v].s);
            set_en = 1'b1;
            step();
            set_en = 1'b0;
            chk("tbl_ack", set_ack, tbl[v].ack);
            chk("tbl_err", set_err, tbl[v].err);
            scan_digits();
            chk("tbl_digit0", got[0], tbl[v].d0);
            chk("tbl_digit1", got[1], tbl[v].d1);
        end

        // Rollover 23:59:58 -> 00:00:00
        mode12 = 1'b0;
        set_h = 5'd23; set_m = 6'd59; set_s = 6'd58;
        set_en = 1'b1;
        run = 1'b1;
        step();
        set_en = 1'b0;
        wait_tick(n);
        chk("load_to_tick", n, CLK_HZ);
        wait_tick(n);
        chk("tick_period", n, CLK_HZ);
        run = 1'b0;
        scan_digits();
        exp8 = '{8'hFC, 8'hFC, 8'h02, 8'hFC, 8'hFC, 8'h02, 8'hFC, 8'hFC};
        check_digits("rollover_digit");

        // Load coinciding with the tick wrap
        run = 1'b1;
        wait_tick(n);
        chk("run_to_tick", n, CLK_HZ);
        step();
        step();
        step();
        set_h = 5'd7; set_m = 6'd8; set_s = 6'd9;
        set_en = 1'b1;
        step();
        set_en = 1'b0;
        chk("collide_no_tick", sec_tick, 1'b0);
        chk("collide_ack", set_ack, 1'b1);
        run = 1'b0;
        scan_digits();
        exp8 = '{8'hFC, 8'hE0, 8'h02, 8'hFC, 8'hFE, 8'h02, 8'hFC, 8'hF6};
        check_digits("collide_digit");

        // Pause then resume
        for (int k = 0; k < 10; k++) step();
        run = 1'b1;
        wait_tick(n);
        chk("resume_to_tick", n, CLK_HZ);

        // Randomised traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            run = ($urandom % 8) != 0;
            if ($urandom % 16 == 0) mode12 = ~mode12;
            set_en = ($urandom % 12) == 0;
            set_h = 5'($urandom_range(0, 31));
            set_m = 6'($urandom_range(0, 63));
            set_s = 6'($urandom_range(0, 63));
            step();
        end
        set_en = 1'b0;

        // Asynchronous reset in the middle of a slot and a load
        set_h = 5'd10; set_m = 6'd11; set_s = 6'd12;
        set_en = 1'b1;
        #3 rst = 1'b0;
        #1 check_zero("async_reset_outputs");
        set_en = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
